parity_chk: RTL and testbench

- Serial parity checker/deserialiser. It is the receive-side counterpart of the serial running-parity generator.
- Accepts a framed bit stream: DATA_W data bits, LSB first, followed by one parity bit.
- Recovers the parallel word and flags a parity mismatch.
- Sits at the receiving end of the single-bit parity link, feeding word-level consumers.

---
 rtl/parity_pkg.sv | 19 +
 rtl/parity_acc.sv | 33 +++
 rtl/parity_chk.sv | 166 ++++++++++++++++
 tb/tb_parity_chk.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and helpers for the serial parity checker.
package parity_pkg;

    // Frame reception states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_e;

    // Width of the optional parity-error frame counter
    localparam int ERR_CNT_W = 16;

    // Bit-position counter width; counter only ever holds 0..dw-1
    function automatic int cnt_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/parity_acc.sv
// Running XOR accumulator over the bits of one frame.
// load_i restarts the accumulation with the current bit, en_i qualifies
// every update, clr_i returns the state to zero (highest priority).
module parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic load_i,
    input  logic clr_i,
    input  logic x_i,
    output logic acc_o
);

    logic acc_q;

    // Accumulate XOR of qualified bits; sof reloads, completion clears
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else if (clr_i) begin
            acc_q <= 1'b0;
        end else if (en_i && load_i) begin
            acc_q <= x_i;
        end else if (en_i) begin
            acc_q <= acc_q ^ x_i;
        end else begin
            acc_q <= acc_q;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/parity_chk.sv
// Serial parity checker / deserialiser.
// Receives DATA_W data bits LSB first followed by one parity bit, recovers
// the word and flags a parity mismatch. A sof in the middle of a frame
// discards the partial frame (frame_abort pulse) and starts a new one.
// Optional feature: define PARITY_CHK_ERR_CNT_EN to add the saturating
// err_cnt output counting frames completed with a parity error.
module parity_chk
    import parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 x,
    input  logic                 x_valid,
    input  logic                 sof,
    output logic [DATA_W-1:0]    dout,
    output logic                 dout_valid,
    output logic                 parity_err,
    output logic                 frame_abort
`ifdef PARITY_CHK_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    localparam int              CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic            ODD_B    = 1'(PARITY_ODD);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   dout_q;
    logic                dout_valid_q;
    logic                parity_err_q;
    logic                frame_abort_q;

    logic [DATA_W-1:0]   shift_ins_d;
    logic [DATA_W-1:0]   shift_first_d;
    logic                parity_err_d;
    logic                acc_s;
    logic                acc_en_s;
    logic                acc_load_s;
    logic                complete_s;

    // The parity bit closes the frame only when it is not a new sof
    assign complete_s = x_valid && !sof && (state_q == PAR);

    // Bits are only accumulated once a frame has been opened by sof
    assign acc_en_s   = x_valid && (sof || (state_q != IDLE));
    assign acc_load_s = sof;

    parity_acc u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (acc_en_s),
        .load_i (acc_load_s),
        .clr_i  (complete_s),
        .x_i    (x),
        .acc_o  (acc_s)
    );

    // Next shift-register images and the parity verdict for the current bit
    always_comb begin
        shift_ins_d        = shift_q;
        shift_ins_d[cnt_q] = x;
        shift_first_d      = {{(DATA_W-1){1'b0}}, x};
        parity_err_d       = ((acc_s ^ x) != ODD_B);
    end

    // Frame FSM with registered word/flag outputs and single-cycle pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= CNT_ZERO;
            shift_q       <= {DATA_W{1'b0}};
            dout_q        <= {DATA_W{1'b0}};
            dout_valid_q  <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            dout_valid_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            if (x_valid) begin
                case (state_q)
                    IDLE: begin
                        if (sof) begin
                            shift_q <= shift_first_d;
                            cnt_q   <= CNT_ONE;
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    DATA: begin
                        if (sof) begin
                            frame_abort_q <= 1'b1;
                            shift_q       <= shift_first_d;
                            cnt_q         <= CNT_ONE;
                            state_q       <= DATA;
                        end else begin
                            shift_q <= shift_ins_d;
                            if (cnt_q == CNT_LAST) begin
                                cnt_q   <= CNT_ZERO;
                                state_q <= PAR;
                            end else begin
                                cnt_q   <= cnt_q + CNT_ONE;
                                state_q <= DATA;
                            end
                        end
                    end
                    PAR: begin
                        if (sof) begin
                            frame_abort_q <= 1'b1;
                            shift_q       <= shift_first_d;
                            cnt_q         <= CNT_ONE;
                            state_q       <= DATA;
                        end else begin
                            dout_q       <= shift_q;
                            parity_err_q <= parity_err_d;
                            dout_valid_q <= 1'b1;
                            cnt_q        <= CNT_ZERO;
                            state_q      <= IDLE;
                        end
                    end
                    default: begin
                        cnt_q   <= CNT_ZERO;
                        state_q <= IDLE;
                    end
                endcase
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_abort = frame_abort_q;

`ifdef PARITY_CHK_ERR_CNT_EN
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Saturating count of completed frames that fail the parity check
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= {ERR_CNT_W{1'b0}};
        end else if (complete_s && parity_err_d && (err_cnt_q != ERR_MAX)) begin
            err_cnt_q <= err_cnt_q + ERR_ONE;
        end else begin
            err_cnt_q <= err_cnt_q;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_chk.sv
// Directed self-checking bench for parity_chk: one even-parity and one
// odd-parity instance share the same serial stimulus.
module tb_parity_chk;

    logic       clk;
    logic       rst_n;
    logic       x;
    logic       x_valid;
    logic       sof;
    logic [7:0] e_dout, o_dout;
    logic       e_dv, o_dv, e_perr, o_perr, e_abort, o_abort;
`ifdef PARITY_CHK_ERR_CNT_EN
    logic [15:0] e_errcnt, o_errcnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int vld_cnt  = 0;
    int abort_cnt = 0;
    int both_cnt = 0;

    parity_chk #(.DATA_W(8), .PARITY_ODD(0)) u_even (
        .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .sof(sof),
        .dout(e_dout), .dout_valid(e_dv), .parity_err(e_perr), .frame_abort(e_abort)
`ifdef PARITY_CHK_ERR_CNT_EN
        , .err_cnt(e_errcnt)
`endif
    );

    parity_chk #(.DATA_W(8), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .sof(sof),
        .dout(o_dout), .dout_valid(o_dv), .parity_err(o_perr), .frame_abort(o_abort)
`ifdef PARITY_CHK_ERR_CNT_EN
        , .err_cnt(o_errcnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, pass the rising edge, observe 1 time unit later
    task automatic drive(input logic xb, input logic v, input logic s);
        x = xb; x_valid = v; sof = s;
        @(posedge clk);
        #1;
        if (e_dv) vld_cnt++;
        if (e_abort) abort_cnt++;
        if ((e_dv && e_abort) || (o_dv && o_abort)) both_cnt++;
    endtask

    task automatic send_frame(input logic [7:0] w, input logic p, input int stall_at, input int stall_len);
        for (int i = 0; i < 8; i++) begin
            drive(w[i], 1'b1, (i == 0));
            if (i == stall_at) begin
                for (int j = 0; j < stall_len; j++) drive(1'b1, 1'b0, 1'b0);
            end
        end
        drive(p, 1'b1, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({e_dout, e_dv, e_perr, e_abort, o_dout, o_dv, o_perr, o_abort} !== 22'd0)
            $display("FAIL reset_outputs: got e=%h/%b/%b/%b o=%h/%b/%b/%b want all zero",
                     e_dout, e_dv, e_perr, e_abort, o_dout, o_dv, o_perr, o_abort);
        else n_pass++;
`ifdef PARITY_CHK_ERR_CNT_EN
        n_checks++;
        if (e_errcnt !== 16'd0 || o_errcnt !== 16'd0)
            $display("FAIL reset_errcnt: got %0d/%0d want 0/0", e_errcnt, o_errcnt);
        else n_pass++;
`endif
        rst_n = 1'b1;
        // Bits without sof while idle are ignored
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (vld_cnt !== 0 || abort_cnt !== 0)
            $display("FAIL idle_ignore: got vld=%0d abort=%0d want 0/0", vld_cnt, abort_cnt);
        else n_pass++;
    endtask

    task automatic test_even_ok;
        int v0;
        v0 = vld_cnt;
        send_frame(8'hA5, 1'b0, -1, 0);
        n_checks++;
        if (e_dv !== 1'b1 || e_dout !== 8'hA5 || e_perr !== 1'b0)
            $display("FAIL a5_even_ok: got dv=%b dout=%h perr=%b want 1/a5/0", e_dv, e_dout, e_perr);
        else n_pass++;
        n_checks++;
        if (o_dv !== 1'b1 || o_dout !== 8'hA5 || o_perr !== 1'b1)
            $display("FAIL a5_odd_view: got dv=%b dout=%h perr=%b want 1/a5/1", o_dv, o_dout, o_perr);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (e_dv !== 1'b0 || (vld_cnt - v0) !== 1)
            $display("FAIL a5_single_pulse: got dv=%b pulses=%0d want 0/1", e_dv, vld_cnt - v0);
        else n_pass++;
    endtask

    task automatic test_even_err;
        send_frame(8'hA5, 1'b1, -1, 0);
        n_checks++;
        if (e_dv !== 1'b1 || e_dout !== 8'hA5 || e_perr !== 1'b1 || o_perr !== 1'b0)
            $display("FAIL a5_even_err: got dv=%b dout=%h perr=%b operr=%b want 1/a5/1/0",
                     e_dv, e_dout, e_perr, o_perr);
        else n_pass++;
`ifdef PARITY_CHK_ERR_CNT_EN
        n_checks++;
        if (e_errcnt !== 16'd1 || o_errcnt !== 16'd1)
            $display("FAIL errcnt_first: got %0d/%0d want 1/1", e_errcnt, o_errcnt);
        else n_pass++;
`endif
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall;
        int v0;
        v0 = vld_cnt;
        for (int i = 0; i < 5; i++) drive(i[0] ? 1'b0 : 1'b0, 1'b0, 1'b0);
        v0 = vld_cnt;
        send_frame(8'h3C, 1'b0, 4, 3);
        n_checks++;
        if (e_dv !== 1'b1 || e_dout !== 8'h3C || e_perr !== 1'b0 || o_perr !== 1'b1)
            $display("FAIL stall_3c: got dv=%b dout=%h perr=%b operr=%b want 1/3c/0/1",
                     e_dv, e_dout, e_perr, o_perr);
        else n_pass++;
        n_checks++;
        if ((vld_cnt - v0) !== 1)
            $display("FAIL stall_pulses: got %0d want 1", vld_cnt - v0);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_abort;
        int a0;
        logic [7:0] ones;
        a0 = abort_cnt;
        ones = 8'hFF;
        for (int i = 0; i < 5; i++) drive(ones[i], 1'b1, (i == 0));
        // dout must still hold the previous word mid-frame
        n_checks++;
        if (e_dout !== 8'h3C || e_dv !== 1'b0)
            $display("FAIL dout_hold: got dout=%h dv=%b want 3c/0", e_dout, e_dv);
        else n_pass++;
        drive(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (e_abort !== 1'b1 || o_abort !== 1'b1 || e_dv !== 1'b0)
            $display("FAIL abort_pulse: got ea=%b oa=%b dv=%b want 1/1/0", e_abort, o_abort, e_dv);
        else n_pass++;
        for (int i = 1; i < 8; i++) drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (e_dv !== 1'b1 || e_dout !== 8'h01 || e_perr !== 1'b0 || o_perr !== 1'b1)
            $display("FAIL abort_01: got dv=%b dout=%h perr=%b operr=%b want 1/01/0/1",
                     e_dv, e_dout, e_perr, o_perr);
        else n_pass++;
        n_checks++;
        if ((abort_cnt - a0) !== 1)
            $display("FAIL abort_count: got %0d want 1", abort_cnt - a0);
        else n_pass++;
    endtask

    task automatic test_par_abort;
        int a0;
        logic [7:0] ones;
        a0 = abort_cnt;
        ones = 8'hFF;
        for (int i = 0; i < 8; i++) drive(ones[i], 1'b1, (i == 0));
        send_frame(8'h81, 1'b0, -1, 0);
        n_checks++;
        if (e_dv !== 1'b1 || e_dout !== 8'h81 || e_perr !== 1'b0 || (abort_cnt - a0) !== 1)
            $display("FAIL par_abort_81: got dv=%b dout=%h perr=%b aborts=%0d want 1/81/0/1",
                     e_dv, e_dout, e_perr, abort_cnt - a0);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = vld_cnt;
        send_frame(8'h00, 1'b1, -1, 0);
        n_checks++;
        if (o_dv !== 1'b1 || o_dout !== 8'h00 || o_perr !== 1'b0 || e_perr !== 1'b1)
            $display("FAIL b2b_first: got dv=%b dout=%h operr=%b eperr=%b want 1/00/0/1",
                     o_dv, o_dout, o_perr, e_perr);
        else n_pass++;
        send_frame(8'h00, 1'b0, -1, 0);
        n_checks++;
        if (o_dv !== 1'b1 || o_dout !== 8'h00 || o_perr !== 1'b1 || e_perr !== 1'b0)
            $display("FAIL b2b_second: got dv=%b dout=%h operr=%b eperr=%b want 1/00/1/0",
                     o_dv, o_dout, o_perr, e_perr);
        else n_pass++;
        n_checks++;
        if ((vld_cnt - v0) !== 2)
            $display("FAIL b2b_pulses: got %0d want 2", vld_cnt - v0);
        else n_pass++;
`ifdef PARITY_CHK_ERR_CNT_EN
        n_checks++;
        if (e_errcnt !== 16'd2 || o_errcnt !== 16'd5)
            $display("FAIL errcnt_b2b: got %0d/%0d want 2/5", e_errcnt, o_errcnt);
        else n_pass++;
`endif
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        int a0;
        logic [7:0] w;
        w = 8'h5A;
        for (int i = 0; i < 4; i++) drive(w[i], 1'b1, (i == 0));
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        a0 = abort_cnt;
        n_checks++;
        if ({e_dout, e_dv, e_perr, e_abort, o_dout, o_dv, o_perr, o_abort} !== 22'd0)
            $display("FAIL mid_reset_outputs: got e=%h/%b/%b/%b o=%h/%b/%b/%b want all zero",
                     e_dout, e_dv, e_perr, e_abort, o_dout, o_dv, o_perr, o_abort);
        else n_pass++;
        send_frame(8'h5A, 1'b0, -1, 0);
        n_checks++;
        if (e_dv !== 1'b1 || e_dout !== 8'h5A || e_perr !== 1'b0 || o_perr !== 1'b1 || (abort_cnt - a0) !== 0)
            $display("FAIL after_reset_5a: got dv=%b dout=%h perr=%b operr=%b aborts=%0d want 1/5a/0/1/0",
                     e_dv, e_dout, e_perr, o_perr, abort_cnt - a0);
        else n_pass++;
`ifdef PARITY_CHK_ERR_CNT_EN
        n_checks++;
        if (e_errcnt !== 16'd0 || o_errcnt !== 16'd1)
            $display("FAIL errcnt_after_reset: got %0d/%0d want 0/1", e_errcnt, o_errcnt);
        else n_pass++;
`endif
        drive(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (both_cnt !== 0)
            $display("FAIL valid_abort_overlap: got %0d cycles want 0", both_cnt);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; x = 1'b0; x_valid = 1'b0; sof = 1'b0;
        test_reset();
        test_even_ok();
        test_even_err();
        test_stall();
        test_abort();
        test_par_abort();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
